// File: rtl/mips_debug_ctrl.sv
// Run-control and debug readout for the MIPS top: CPU clock-enable gating, PC breakpoints,
// cycle/instruction counters and a handshaked register/memory dump over the async debug read ports.
module mips_debug_ctrl #(
  parameter int NUM_BP = 2,
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 6
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Run,
  input  logic                Halt,
  input  logic                StepReq,
  input  logic [31:0]         PC,
  input  logic [NUM_BP*32-1:0] BpAddr,
  input  logic [NUM_BP-1:0]   BpEn,
  output logic                CpuEn,
  output logic                Halted,
  output logic [NUM_BP-1:0]   BpHit,
  output logic [CNT_W-1:0]    CycleCnt,
  output logic [CNT_W-1:0]    InstrCnt,
  input  logic                DumpReq,
  input  logic                DumpSel,
  output logic [REG_AW-1:0]   DumpReg,
  output logic [MEM_AW-1:0]   DumpMem,
  input  logic [31:0]         RegData,
  input  logic [31:0]         MemData,
  output logic [31:0]         DumpOut,
  output logic                DumpValid,
  input  logic                DumpReady,
  output logic                DumpDone
);

  typedef enum logic [2:0] {
    S_HALT,
    S_RUN,
    S_STEP,
    S_DUMP_LOAD,
    S_DUMP_WAIT
  } state_t;

  state_t              state;
  logic                skip;
  logic                sel;
  logic [NUM_BP-1:0]   match;
  logic                hit;
  logic                last_word;
  logic                accept;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = BpEn[i] && (PC == BpAddr[32*i +: 32]);
    end
  end

  // skip masks the breakpoint we are resuming from for the first RUN cycle
  assign hit       = (|match) && !skip;
  assign accept    = DumpValid && DumpReady;
  assign last_word = sel ? (DumpMem == {MEM_AW{1'b1}}) : (DumpReg == {REG_AW{1'b1}});
  assign Halted    = (state == S_HALT);

  always_comb begin
    CpuEn = 1'b0;
    case (state)
      S_RUN:   CpuEn = !hit && !Halt;
      S_STEP:  CpuEn = 1'b1;
      default: CpuEn = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= S_HALT;
      skip      <= 1'b0;
      sel       <= 1'b0;
      BpHit     <= '0;
      DumpReg   <= '0;
      DumpMem   <= '0;
      DumpOut   <= '0;
      DumpValid <= 1'b0;
      DumpDone  <= 1'b0;
    end else begin
      DumpDone <= 1'b0;
      case (state)
        S_HALT: begin
          if (Halt) begin
            state <= S_HALT;
          end else if (DumpReq) begin
            state <= S_DUMP_LOAD;
            sel   <= DumpSel;
            if (DumpSel) DumpMem <= '0;
            else         DumpReg <= '0;
          end else if (StepReq) begin
            state <= S_STEP;
            BpHit <= '0;
          end else if (Run) begin
            state <= S_RUN;
            skip  <= 1'b1;
            BpHit <= '0;
          end
        end
        S_RUN: begin
          skip <= 1'b0;
          if (hit) begin
            state <= S_HALT;
            BpHit <= BpHit | match;
          end else if (Halt || !Run) begin
            state <= S_HALT;
          end
        end
        S_STEP: begin
          state <= S_HALT;
        end
        S_DUMP_LOAD: begin
          DumpOut   <= sel ? MemData : RegData;
          DumpValid <= 1'b1;
          state     <= S_DUMP_WAIT;
        end
        S_DUMP_WAIT: begin
          if (accept) begin
            DumpValid <= 1'b0;
            if (last_word) begin
              DumpDone <= 1'b1;
              state    <= S_HALT;
            end else begin
              if (sel) DumpMem <= DumpMem + 1'b1;
              else     DumpReg <= DumpReg + 1'b1;
              state <= S_DUMP_LOAD;
            end
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      CycleCnt <= CycleCnt + 1'b1;
      if (CpuEn) InstrCnt <= InstrCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Randomized bench for mips_debug_ctrl: scenario-level expectations for run/step/breakpoint
// behaviour, counter totals, and a word scoreboard for register and memory dumps.
module tb_mips_debug_ctrl;

  logic        CLK = 1'b0;
  logic        Reset, Run, Halt, StepReq, DumpReq, DumpSel, DumpReady;
  logic [31:0] PC;
  logic [63:0] BpAddr;
  logic [1:0]  BpEn;
  logic        CpuEn, Halted, DumpValid, DumpDone;
  logic [1:0]  BpHit;
  logic [31:0] CycleCnt, InstrCnt, RegData, MemData, DumpOut;
  logic [4:0]  DumpReg;
  logic [5:0]  DumpMem;

  logic        CpuEn4, Halted4, DumpValid4, DumpDone4;
  logic [1:0]  BpHit4;
  logic [3:0]  CycleCnt4, InstrCnt4;
  logic [4:0]  DumpReg4;
  logic [5:0]  DumpMem4;
  logic [31:0] DumpOut4;

  logic [31:0] regs [32];
  logic [31:0] mem  [64];
  logic        pc_load;
  logic [31:0] pc_init;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cycle;
  int exp_instr;

  mips_debug_ctrl dut (
    .CLK(CLK), .Reset(Reset), .Run(Run), .Halt(Halt), .StepReq(StepReq), .PC(PC),
    .BpAddr(BpAddr), .BpEn(BpEn), .CpuEn(CpuEn), .Halted(Halted), .BpHit(BpHit),
    .CycleCnt(CycleCnt), .InstrCnt(InstrCnt), .DumpReq(DumpReq), .DumpSel(DumpSel),
    .DumpReg(DumpReg), .DumpMem(DumpMem), .RegData(RegData), .MemData(MemData),
    .DumpOut(DumpOut), .DumpValid(DumpValid), .DumpReady(DumpReady), .DumpDone(DumpDone)
  );

  mips_debug_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .Reset(Reset), .Run(Run), .Halt(Halt), .StepReq(StepReq), .PC(PC),
    .BpAddr(BpAddr), .BpEn(BpEn), .CpuEn(CpuEn4), .Halted(Halted4), .BpHit(BpHit4),
    .CycleCnt(CycleCnt4), .InstrCnt(InstrCnt4), .DumpReq(DumpReq), .DumpSel(DumpSel),
    .DumpReg(DumpReg4), .DumpMem(DumpMem4), .RegData(RegData), .MemData(MemData),
    .DumpOut(DumpOut4), .DumpValid(DumpValid4), .DumpReady(DumpReady), .DumpDone(DumpDone4)
  );

  always #5 CLK = ~CLK;

  // Environment: asynchronous debug read ports and a CPU whose PC advances 4 per enabled cycle
  assign RegData = regs[DumpReg];
  assign MemData = mem[DumpMem];

  always @(posedge CLK) begin
    if (pc_load)    PC <= pc_init;
    else if (CpuEn) PC <= PC + 32'd4;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    exp_cycle++;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_init = v;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
  endtask

  task automatic chk_counters(input string tag);
    check({tag, "_cyc"},   CycleCnt,  64'(exp_cycle));
    check({tag, "_instr"}, InstrCnt,  64'(exp_instr));
    check({tag, "_cyc4"},  CycleCnt4, 64'(exp_cycle % 16));
    check({tag, "_ins4"},  InstrCnt4, 64'(exp_instr % 16));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_halted"}, Halted, 1);
    check({tag, "_cpuen"},  CpuEn, 0);
    check({tag, "_bphit"},  BpHit, 0);
    check({tag, "_cyc"},    CycleCnt, 0);
    check({tag, "_instr"},  InstrCnt, 0);
    check({tag, "_dreg"},   DumpReg, 0);
    check({tag, "_dmem"},   DumpMem, 0);
    check({tag, "_dout"},   DumpOut, 0);
    check({tag, "_dvalid"}, DumpValid, 0);
    check({tag, "_ddone"},  DumpDone, 0);
    check({tag, "_cyc4"},   CycleCnt4, 0);
    check({tag, "_ins4"},   InstrCnt4, 0);
  endtask

  // RUN lasts k cycles, all enabled; the last one sees Run=0 and returns to HALT
  task automatic run_test(input int k);
    Run = 1'b1;
    tick();
    for (int i = 1; i <= k; i++) begin
      if (i == k) Run = 1'b0;
      @(negedge CLK);
      check("run_en", CpuEn, 1);
      tick();
      exp_instr++;
    end
    @(negedge CLK);
    check("run_halted", Halted, 1);
    check("run_cpuen", CpuEn, 0);
    chk_counters("run");
    tick();
  endtask

  task automatic halt_test();
    int k;
    Run  = 1'b1;
    Halt = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("halt_prio_halted", Halted, 1);
      check("halt_prio_cpuen", CpuEn, 0);
      tick();
    end
    Halt = 1'b0;
    tick();
    k = $urandom_range(2, 6);
    repeat (k) begin
      tick();
      exp_instr++;
    end
    Halt = 1'b1;
    @(negedge CLK);
    check("halt_gate", CpuEn, 0);
    check("halt_running", Halted, 0);
    tick();
    @(negedge CLK);
    check("halt_stop", Halted, 1);
    chk_counters("halt");
    Run  = 1'b0;
    Halt = 1'b0;
    tick();
  endtask

  task automatic step_test();
    int n, k;
    n = $urandom_range(1, 4);
    repeat (n) begin
      StepReq = 1'b1;
      @(negedge CLK);
      check("step_pre_en", CpuEn, 0);
      tick();
      StepReq = 1'b0;
      @(negedge CLK);
      check("step_en", CpuEn, 1);
      check("step_halted", Halted, 0);
      tick();
      exp_instr++;
      @(negedge CLK);
      check("step_back", Halted, 1);
      check("step_off", CpuEn, 0);
      tick();
    end
    // StepReq while running has no effect on the instruction count
    Run = 1'b1;
    tick();
    k = $urandom_range(3, 8);
    for (int i = 1; i <= k; i++) begin
      StepReq = 1'($urandom);
      if (i == k) Run = 1'b0;
      tick();
      exp_instr++;
    end
    StepReq = 1'b0;
    @(negedge CLK);
    check("step_run_halted", Halted, 1);
    chk_counters("step");
    tick();
  endtask

  task automatic bp_test();
    int b, t, cnt;
    logic en_o, same, hb;
    logic [31:0] a [2];
    logic [1:0]  exp_hit;
    b    = $urandom_range(2, 10);
    t    = $urandom_range(0, 1);
    en_o = 1'($urandom);
    same = 1'($urandom);
    a[t]     = 32'(4 * b);
    a[1 - t] = en_o ? (same ? 32'(4 * b) : 32'(4 * (b + 6)))
                    : (same ? 32'(4 * b) : 32'(4 * (b - 1)));
    BpAddr = {a[1], a[0]};
    BpEn   = '0;
    BpEn[t]     = 1'b1;
    BpEn[1 - t] = en_o;
    exp_hit = '0;
    exp_hit[t]     = 1'b1;
    exp_hit[1 - t] = en_o && same;
    set_pc(32'd0);
    Run = 1'b1;
    tick();
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (!CpuEn) break;
      tick();
      exp_instr++;
      cnt++;
    end
    check("bp_cycles", 64'(cnt), 64'(b));
    check("bp_pc", PC, 64'(4 * b));
    check("bp_running", Halted, 0);
    hb   = 1'($urandom);
    Halt = hb;
    tick();
    Halt = 1'b0;
    @(negedge CLK);
    check("bp_halted", Halted, 1);
    check("bp_hit", BpHit, 64'(exp_hit));
    chk_counters("bp");
    tick();
    @(negedge CLK);
    check("bp_resume_en", CpuEn, 1);
    check("bp_resume_clr", BpHit, 0);
    check("bp_resume_pc", PC, 64'(4 * b));
    Run = 1'b0;
    tick();
    exp_instr++;
    @(negedge CLK);
    check("bp_resume_halted", Halted, 1);
    check("bp_resume_next", PC, 64'(4 * b + 4));
    BpEn = '0;
    tick();
  endtask

  // mode 0: always ready, 1: ready toggles every cycle, 2: random ready
  task automatic dump_test(input logic sel, input int mode);
    int depth, ticks, done_cnt, en_seen;
    logic prev_hold;
    logic [31:0] prev_word, want;
    logic [31:0] got [$];
    foreach (regs[i]) regs[i] = $urandom;
    foreach (mem[i])  mem[i]  = $urandom;
    depth     = sel ? 64 : 32;
    ticks     = 0;
    done_cnt  = 0;
    en_seen   = 0;
    prev_hold = 1'b0;
    prev_word = '0;
    DumpSel = sel;
    DumpReq = 1'b1;
    tick();
    DumpReq = 1'b0;
    for (int c = 0; c < 800; c++) begin
      DumpSel   = 1'($urandom);
      Run       = 1'($urandom);
      Halt      = 1'($urandom);
      StepReq   = 1'($urandom);
      DumpReq   = 1'($urandom);
      DumpReady = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(c % 2) : 1'($urandom);
      @(negedge CLK);
      if (prev_hold) check("dump_hold", {DumpValid, DumpOut}, {31'd0, 1'b1, prev_word});
      if (DumpDone) begin
        done_cnt++;
        break;
      end
      if (CpuEn) en_seen++;
      if (DumpValid && DumpReady) got.push_back(DumpOut);
      prev_hold = DumpValid && !DumpReady;
      prev_word = DumpOut;
      tick();
      ticks++;
    end
    Run = 1'b0; Halt = 1'b0; StepReq = 1'b0; DumpReq = 1'b0; DumpReady = 1'b0;
    check("dump_done_seen", 64'(done_cnt), 1);
    check("dump_cpuen_off", 64'(en_seen), 0);
    check("dump_end_halted", Halted, 1);
    check("dump_end_valid", DumpValid, 0);
    if (mode == 0) check("dump_cycles", 64'(ticks), 64'(2 * depth));
    check("dump_words", 64'(got.size()), 64'(depth));
    for (int i = 0; i < got.size() && i < depth; i++) begin
      want = sel ? mem[i] : regs[i];
      check("dump_word", {32'(i), got[i]}, {32'(i), want});
    end
    tick();
    @(negedge CLK);
    check("dump_done_pulse", DumpDone, 0);
    chk_counters("dump");
    tick();
  endtask

  task automatic reset_mid_dump();
    int n;
    n = 0;
    DumpSel   = 1'($urandom);
    DumpReq   = 1'b1;
    DumpReady = 1'b1;
    tick();
    DumpReq = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (DumpValid && DumpReady) n++;
      if (n == 5) break;
      tick();
    end
    check("rst_reach_word5", 64'(n), 5);
    Reset = 1'b1;
    #1;
    chk_reset("rst_async");
    repeat (2) begin
      @(negedge CLK);
      chk_reset("rst_hold");
    end
    @(posedge CLK);
    #1;
    Reset     = 1'b0;
    DumpReady = 1'b0;
    exp_cycle = 0;
    exp_instr = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; Run = 1'b0; Halt = 1'b0; StepReq = 1'b0; DumpReq = 1'b0;
    DumpSel = 1'b0; DumpReady = 1'b0; BpEn = '0; BpAddr = '0;
    pc_load = 1'b0; pc_init = '0;
    exp_cycle = 0;
    exp_instr = 0;
    foreach (regs[i]) regs[i] = $urandom;
    foreach (mem[i])  mem[i]  = $urandom;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_reset("por");
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    set_pc(32'd0);
    @(negedge CLK);
    chk_counters("idle");
    tick();

    for (int r = 0; r < 3; r++) begin
      run_test($urandom_range(3, 12));
      halt_test();
      step_test();
      bp_test();
      bp_test();
      dump_test(1'b0, r % 3);
      dump_test(1'b1, (r + 1) % 3);
    end

    reset_mid_dump();
    repeat (20) tick();
    @(negedge CLK);
    chk_counters("wrap_idle");
    tick();
    set_pc(32'd0);
    run_test(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_debug_ctrl.md
Name: mips_debug_ctrl

Overview:
Run-control and debug-readout unit for the MIPS system top. It gates the CPU through a clock-enable (run/halt/single-step) and halts on PC breakpoints. It also keeps cycle and instruction counters. When halted, it streams register-file or data-memory contents out over a valid/ready handshake, reusing the existing asynchronous debug read ports (ReadReg/RegData, ReadMem/MemData).

Parameters:
NUM_BP, 2, number of PC breakpoint comparators
CNT_W, 32, width of CycleCnt/InstrCnt
REG_AW, 5, register-file debug address width (dump depth 2^REG_AW)
MEM_AW, 6, data-memory debug word-address width (dump depth 2^MEM_AW)

Ports:
CLK  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Run  in  1  level; 1 = let CPU run
Halt  in  1  level; forces halt (priority over Run)
StepReq  in  1  single-cycle pulse; execute one instruction while halted
PC  in  32  current CPU PC
BpAddr  in  NUM_BP*32  breakpoint addresses, bp i at [32*i+31:32*i]
BpEn  in  NUM_BP  per-breakpoint enable
CpuEn  out  1  CPU clock-enable (combinational)
Halted  out  1  1 when in HALT state
BpHit  out  NUM_BP  sticky breakpoint-hit flags
CycleCnt  out  CNT_W  free-running cycle counter
InstrCnt  out  CNT_W  count of cycles with CpuEn=1
DumpReq  in  1  pulse; start dump (accepted only in HALT)
DumpSel  in  1  sampled with DumpReq: 0 = registers, 1 = memory
DumpReg  out  REG_AW  drives CPU debug register address
DumpMem  out  MEM_AW  drives memory debug word address
RegData  in  32  async register read data
MemData  in  32  async memory read data
DumpOut  out  32  dumped word
DumpValid  out  1  DumpOut valid
DumpReady  in  1  consumer accepts DumpOut
DumpDone  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset is asynchronous, active-high. On reset: state HALT, Halted=1, CpuEn=0, BpHit=0, CycleCnt=0, InstrCnt=0, DumpReg=0, DumpMem=0, DumpOut=0, DumpValid=0, DumpDone=0, skip flag=0. Reset mid-dump or mid-run aborts immediately; no DumpDone is emitted.
- States: HALT, RUN, STEP, DUMP_LOAD, DUMP_WAIT.
- HALT transitions, in priority order:
  - Halt=1: stay in HALT.
  - DumpReq=1: go to DUMP_LOAD, latch DumpSel, clear the selected address to 0.
  - StepReq=1: go to STEP.
  - Run=1: go to RUN and set skip=1.
  - Entering RUN or STEP clears BpHit.
- RUN:
  - hit = OR over i of (BpEn[i] && PC == BpAddr[i]) && !skip.
  - CpuEn = !hit && !Halt.
  - If hit: go to HALT and set BpHit[i] for each matching i.
  - Else if Halt or !Run: go to HALT.
  - skip clears after the first RUN cycle, so resuming from a breakpoint PC executes that instruction.
  - Halt and a hit in the same cycle: go to HALT, BpHit is still set.
- STEP: CpuEn=1 for exactly one cycle (breakpoints ignored), then HALT. StepReq outside HALT is ignored.
- DumpReq outside HALT is ignored.
- DUMP_LOAD: DumpOut <= (sel ? MemData : RegData) at the current address, DumpValid <= 1, go to DUMP_WAIT.
- DUMP_WAIT: hold DumpOut and DumpValid until DumpValid && DumpReady.
  - On accept: if address is last (2^REG_AW-1 or 2^MEM_AW-1), set DumpValid=0, pulse DumpDone, go to HALT.
  - Otherwise increment the address, DumpValid=0, go to DUMP_LOAD.
  - Sustained throughput is one word per 2 cycles.
- Halt, Run and StepReq are ignored during a dump; CpuEn=0 throughout.
- Counters:
  - CycleCnt increments every cycle out of reset.
  - InstrCnt increments on each cycle with CpuEn=1.
  - Both wrap modulo 2^CNT_W with no saturation.
- Halted = (state == HALT); it is 0 during STEP, RUN and DUMP.

Test Plan:
- Reset, then Run=1 for 10 cycles, then Run=0 -> InstrCnt=10, CycleCnt=11 (includes the return cycle), Halted=1, CpuEn=0.
- BpEn=01, BpAddr[0]=0x0000000C, Run=1 from PC=0 (PC steps by 4) -> CpuEn=0 in the cycle PC=0x0C, BpHit=01, InstrCnt=3. Keeping Run=1 resumes and executes 0x0C (skip), BpHit clears.
- Halted, StepReq pulse x3 -> exactly 3 CpuEn cycles, InstrCnt +3. StepReq while RUN -> no effect.
- Halted, DumpReq with DumpSel=0, DumpReady=1 -> 32 words with DumpOut = RegData(n) for n=0..31, DumpDone 1 cycle after word 31, 64 cycles total. DumpSel=1 -> 64 words.
- Dump with DumpReady toggling 1/0 -> no word lost or duplicated, DumpOut stable while DumpValid && !DumpReady.
- Assert Reset mid-dump at word 5, and CNT_W=4 wrap (16 cycles) -> all outputs at reset values, no DumpDone, counters wrap from 15 to 0.
